// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (CPU port 0, loader port 1).
// Round-robin with a bounded burst allowance; reads return registered data one cycle
// after grant, writes commit at the grant edge.
module data_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Port 0
  input  logic                  req0_i,
  input  logic [1:0]            we0_i,
  input  logic [DATA_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic                  gnt0_o,
  output logic                  rvalid0_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  // Port 1
  input  logic                  req1_i,
  input  logic [1:0]            we1_i,
  input  logic [DATA_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  gnt1_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  // Memory side
  output logic [1:0]            mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_a_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  localparam int unsigned CntW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic                  last_gnt_q, last_gnt_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                  rsel_q, rsel_d;
  logic                  rpend_q, rpend_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic gnt_any;
  logic win;      // winning port when gnt_any is set
  logic rd_gnt;   // granted access is a read

  // Same-cycle arbitration and memory drive; memory bus is zeroed when idle.
  always_comb begin
    gnt_any  = req0_i | req1_i;
    win      = 1'b0;
    if (req0_i && req1_i) begin
      // Incumbent keeps the bus until it has used up its burst allowance.
      win = (burst_cnt_q < CntMax) ? last_gnt_q : ~last_gnt_q;
    end else begin
      win = req1_i;
    end
    gnt0_o   = gnt_any & ~win;
    gnt1_o   = gnt_any & win;
    mem_we_o = 2'b00;
    mem_a_o  = '0;
    mem_wd_o = '0;
    if (gnt0_o) begin
      mem_we_o = we0_i;
      mem_a_o  = addr0_i;
      mem_wd_o = wdata0_i;
    end else if (gnt1_o) begin
      mem_we_o = we1_i;
      mem_a_o  = addr1_i;
      mem_wd_o = wdata1_i;
    end
    rd_gnt = gnt_any & (mem_we_o == 2'b00);
  end

  // Next-state: burst bookkeeping and read-response capture.
  always_comb begin
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    if (!gnt_any) begin
      burst_cnt_d = '0;
    end else if (win == last_gnt_q) begin
      if (burst_cnt_q < CntMax) begin
        burst_cnt_d = burst_cnt_q + CntOne;
      end
    end else begin
      last_gnt_d  = win;
      burst_cnt_d = CntOne;
    end

    rpend_d  = rd_gnt;
    rsel_d   = rd_gnt ? win : rsel_q;
    rdata0_d = (rd_gnt && !win) ? mem_rd_i : rdata0_q;
    rdata1_d = (rd_gnt && win) ? mem_rd_i : rdata1_q;
  end

  // State registers; reset discards any in-flight read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= 1'b0;
      burst_cnt_q <= '0;
      rsel_q      <= 1'b0;
      rpend_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rsel_q      <= rsel_d;
      rpend_q     <= rpend_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Response outputs come straight from registered state.
  always_comb begin
    rvalid0_o = rpend_q & ~rsel_q;
    rvalid1_o = rpend_q & rsel_q;
    rdata0_o  = rdata0_q;
    rdata1_o  = rdata1_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios followed by random traffic
// against a behavioural arbitration/memory model.
module tb_data_mem_arbiter;

  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [1:0]    we0, we1;
  logic [DW-1:0] addr0, addr1, wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [1:0]    mem_we;
  logic [DW-1:0] mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_i    (req0),
    .we0_i     (we0),
    .addr0_i   (addr0),
    .wdata0_i  (wdata0),
    .gnt0_o    (gnt0),
    .rvalid0_o (rvalid0),
    .rdata0_o  (rdata0),
    .req1_i    (req1),
    .we1_i     (we1),
    .addr1_i   (addr1),
    .wdata1_i  (wdata1),
    .gnt1_o    (gnt1),
    .rvalid1_o (rvalid1),
    .rdata1_o  (rdata1),
    .mem_we_o  (mem_we),
    .mem_a_o   (mem_a),
    .mem_wd_o  (mem_wd),
    .mem_rd_i  (mem_rd)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic logic [31:0] seed_val(input int i);
    if (i == 4) return 32'hDEADBEEF;   // byte address 0x10
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] we,
                                        input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (we)
      2'b01: r = wd;
      2'b10: if (a[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      2'b11: r[8*a[1:0] +: 8] = wd[7:0];
      default: ;
    endcase
    return r;
  endfunction

  // Environment memory driven by the DUT's memory bus.
  logic [31:0] mem [64];
  logic        init_done = 1'b0;
  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_val(i);
      init_done <= 1'b1;
    end else if (mem_we != 2'b00) begin
      mem[mem_a[7:2]] <= merge(mem[mem_a[7:2]], mem_we, mem_a, mem_wd);
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  int          ref_last = 0;
  int          ref_cnt  = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        q [2][$];
  logic [31:0] hold [2];

  task automatic mon(input int p);
    logic        v;
    logic [31:0] d;
    v = (p == 1) ? rvalid1 : rvalid0;
    d = (p == 1) ? rdata1 : rdata0;
    while (q[p].size() > 0 && q[p][0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout port%0d: no response, expected data %h due cycle %0d",
               p, q[p][0].data, q[p][0].due);
      void'(q[p].pop_front());
    end
    checks++;
    if (q[p].size() > 0 && q[p][0].due == cyc) begin
      if (!v || d !== q[p][0].data) begin
        errors++;
        $display("FAIL read_rsp port%0d cyc %0d: got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                 p, cyc, v, d, q[p][0].data);
      end
      hold[p] = q[p][0].data;
      void'(q[p].pop_front());
    end else if (v !== 1'b0 || d !== hold[p]) begin
      errors++;
      $display("FAIL idle_rsp port%0d cyc %0d: got rvalid=%b rdata=%h want rvalid=0 rdata=%h",
               p, cyc, v, d, hold[p]);
    end
  endtask

  // Response monitor: checks rvalid/rdata just after every edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    mon(0);
    mon(1);
  end

  task automatic check(input string name, input logic [67:0] got, input logic [67:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drive one clock cycle of requests, check arbitration, update the model.
  task automatic cycle(input logic r0, input logic [1:0] w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic [1:0] w1,
                       input logic [31:0] a1, input logic [31:0] d1, output int g);
    logic [1:0]  wv [2];
    logic [31:0] av [2], dv [2];
    logic [67:0] want;
    int          idx;
    rsp_t        e;
    wv[0] = w0; wv[1] = w1; av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
    @(negedge clk);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    if (r0 && r1) g = (ref_cnt < MB) ? ref_last : 1 - ref_last;
    else if (r0)  g = 0;
    else if (r1)  g = 1;
    else          g = -1;
    if (g < 0) want = '0;
    else want = {(g == 0), (g == 1), wv[g], av[g], dv[g]};
    check("grant_bus", {gnt0, gnt1, mem_we, mem_a, mem_wd}, want);
    if (g >= 0) begin
      idx = int'(av[g][7:2]);
      if (wv[g] == 2'b00) begin
        e.data = ref_mem[idx];
        e.due  = cyc + 1;
        q[g].push_back(e);
      end else begin
        ref_mem[idx] = merge(ref_mem[idx], wv[g], av[g], dv[g]);
      end
    end
    if (g < 0) ref_cnt = 0;
    else if (g == ref_last) ref_cnt = (ref_cnt < MB) ? ref_cnt + 1 : MB;
    else begin
      ref_last = g;
      ref_cnt  = 1;
    end
  endtask

  task automatic idle(output int g);
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, g);
  endtask

  int          g;
  int          seq [9];
  logic        pv [2];
  logic [1:0]  pw [2];
  logic [31:0] pa [2], pd [2];

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_val(i);
    hold[0] = '0;
    hold[1] = '0;
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {60'h0, gnt0, gnt1, rvalid0, rvalid1, mem_we, 2'b00},
          68'h0);
    check("reset_rdata", {4'h0, rdata0, rdata1}, 68'h0);
    rst_n = 1'b1;

    // Plain read of the preloaded word.
    cycle(1, 2'b00, 32'h10, 32'h0, 0, 2'b00, 32'h0, 32'h0, g);
    idle(g);
    check("t1_rdata", {35'h0, rvalid0, rdata0}, {35'h0, 1'b1, 32'hDEADBEEF});

    // Write then read-back the next cycle.
    cycle(1, 2'b01, 32'h20, 32'h12345678, 0, 2'b00, 32'h0, 32'h0, g);
    cycle(1, 2'b00, 32'h20, 32'h0, 0, 2'b00, 32'h0, 32'h0, g);
    idle(g);
    check("t2_rdata", {35'h0, rvalid0, rdata0}, {35'h0, 1'b1, 32'h12345678});

    // Both ports reading continuously: bursts of MB alternate.
    for (int i = 0; i < 9; i++) begin
      cycle(1, 2'b00, 32'(4 * i), 32'h0, 1, 2'b00, 32'(4 * i + 4), 32'h0, g);
      seq[i] = g;
    end
    check("t3_grant_seq",
          {59'h0, seq[0][0], seq[1][0], seq[2][0], seq[3][0], seq[4][0], seq[5][0],
           seq[6][0], seq[7][0], seq[8][0]},
          {59'h0, 9'b000011110});
    idle(g);

    // Port 1 alone for a while, then contested: port 0 wins immediately.
    for (int i = 0; i < 6; i++) cycle(0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 32'h8, 32'h0, g);
    cycle(1, 2'b00, 32'hC, 32'h0, 1, 2'b00, 32'h8, 32'h0, g);
    check("t4_contest", 68'(g), 68'd0);
    idle(g);

    // Idle gap clears the burst count; contested cycle goes to last_gnt.
    cycle(0, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h31, 32'hA5, g);
    idle(g);
    cycle(1, 2'b00, 32'h4, 32'h0, 1, 2'b00, 32'h30, 32'h0, g);
    check("t5_last_gnt", 68'(g), 68'd1);
    idle(g);

    // Asynchronous reset while a read response is on the outputs.
    cycle(1, 2'b00, 32'h14, 32'h0, 0, 2'b00, 32'h0, 32'h0, g);
    @(posedge clk);
    #3;
    req0 = 0; req1 = 0;
    rst_n = 1'b0;
    #1;
    check("t6_async_rst", {35'h0, rvalid0, rdata0}, 68'h0);
    q[0].delete();
    q[1].delete();
    hold[0] = '0;
    hold[1] = '0;
    ref_last = 0;
    ref_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 2'b00, 32'h18, 32'h0, 1, 2'b00, 32'h1C, 32'h0, g);
    check("t6_post_rst", 68'(g), 68'd0);

    // Random traffic honouring the hold-until-grant rule, with occasional drops.
    pv[0] = 0; pv[1] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 99) < 55) begin
          pv[p] = 1;
          pw[p] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
          pa[p] = 32'($urandom_range(0, 63));
          pd[p] = $urandom;
        end else if (pv[p] && $urandom_range(0, 99) < 5) begin
          pv[p] = 0;
        end
      end
      cycle(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1], g);
      if (g >= 0) pv[g] = 0;
    end
    repeat (3) idle(g);
    check("drain", 68'(q[0].size() + q[1].size()), 68'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
